// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: valid/ready command sequencer driving an 8-bit universal shift register.
// Optional rotate support is enabled by defining USR_SEQ_ROTATE_EN.
module usr_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             cmd_rotate,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_mode,
  output logic             usr_serial_left,
  output logic             usr_serial_right,
  output logic [WIDTH-1:0] usr_parallel_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state, op;
  logic [CNT_W-1:0] cnt;
  logic             fill, rot, accept, run, go, sr, sl;
  logic [WIDTH-1:0] data;
  assign accept    = cmd_valid & cmd_ready;
  assign run       = state == RUN;
  // NOP and zero-length shifts skip RUN so the register never sees a mode pulse
  assign go        = cmd_op == 2'b11 || (cmd_op != 2'b00 && cmd_count != '0);
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign usr_mode  = run ? op : 2'b00;
  assign usr_parallel_in  = data;
  assign usr_serial_right = run & sr;
  assign usr_serial_left  = run & sl;
`ifdef USR_SEQ_ROTATE_EN
  assign sr = rot && op == 2'b01 ? usr_q[WIDTH-1] : fill;
  assign sl = rot && op == 2'b10 ? usr_q[0] : fill;
  always_ff @(posedge clk or posedge reset)
    if (reset) rot <= 1'b0;
    else if (accept) rot <= cmd_rotate;
`else
  logic unused_rotate;
  assign unused_rotate = cmd_rotate;
  assign rot = 1'b0;
  assign sr  = fill;
  assign sl  = fill;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      op     <= 2'b00;
      cnt    <= '0;
      fill   <= 1'b0;
      data   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op   <= cmd_op;
        fill <= cmd_fill;
        data <= cmd_data;
        cnt  <= cmd_op == 2'b11 ? CNT_W'(1) : cmd_count;
      end else if (run) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done) result <= usr_q;
      state <= state == IDLE ? (accept ? (go ? RUN : DONE) : IDLE)
             : run ? (cnt == CNT_W'(1) ? DONE : RUN) : IDLE;
    end
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer: directed tests of the sequencer driving a behavioural universal shift register.
module tb_usr_shift_sequencer;
  logic       clk = 1'b0, reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_count = '0;
  logic       cmd_fill = 1'b0, cmd_rotate = 1'b0;
  logic [7:0] cmd_data = '0;
  logic [1:0] usr_mode;
  logic       usr_serial_left, usr_serial_right, busy, done;
  logic [7:0] usr_parallel_in, usr_q, result;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_rotate(cmd_rotate),
    .cmd_data(cmd_data), .usr_mode(usr_mode), .usr_serial_left(usr_serial_left),
    .usr_serial_right(usr_serial_right), .usr_parallel_in(usr_parallel_in), .usr_q(usr_q),
    .busy(busy), .done(done), .result(result)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) usr_q <= '0;
    else case (usr_mode)
      2'b01:   usr_q <= {usr_q[6:0], usr_serial_right};
      2'b10:   usr_q <= {usr_serial_left, usr_q[7:1]};
      2'b11:   usr_q <= usr_parallel_in;
      default: usr_q <= usr_q;
    endcase

  // Issues one command and measures it; lat stays 0 if done never arrives.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic fill,
                         input logic rot, input logic [7:0] data, output int lat,
                         output int nact, output logic [1:0] seen, output bit rdy_low);
    @(negedge clk);
    cmd_op = op; cmd_count = cnt; cmd_fill = fill; cmd_rotate = rot; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; nact = 0; seen = 2'b00; rdy_low = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (usr_mode != 2'b00) begin nact++; seen = usr_mode; end
      if (cmd_ready) rdy_low = 1'b0;
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (usr_mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode got %b want 00", usr_mode); end
    n_cmp++; if ({usr_serial_left, usr_serial_right} !== 2'b00) begin n_fail++; $display("FAIL reset_serial got %b want 00", {usr_serial_left, usr_serial_right}); end
    n_cmp++; if (usr_parallel_in !== 8'h00) begin n_fail++; $display("FAIL reset_pin got %h want 00", usr_parallel_in); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load;
    int lat, nact; logic [1:0] seen; bit rl;
    run_cmd(2'b11, 4'd9, 1'b1, 1'b0, 8'hA5, lat, nact, seen, rl);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL load_latency got %0d want 2", lat); end
    n_cmp++; if (nact !== 1) begin n_fail++; $display("FAIL load_mode_cycles got %0d want 1", nact); end
    n_cmp++; if (seen !== 2'b11) begin n_fail++; $display("FAIL load_mode got %b want 11", seen); end
    n_cmp++; if (result !== 8'hA5) begin n_fail++; $display("FAIL load_result got %h want a5", result); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_after got %b want 1", cmd_ready); end
  endtask

  task automatic test_shl;
    int lat, nact; logic [1:0] seen; bit rl;
    run_cmd(2'b01, 4'd3, 1'b1, 1'b0, 8'h00, lat, nact, seen, rl);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL shl_latency got %0d want 4", lat); end
    n_cmp++; if (nact !== 3) begin n_fail++; $display("FAIL shl_mode_cycles got %0d want 3", nact); end
    n_cmp++; if (seen !== 2'b01) begin n_fail++; $display("FAIL shl_mode got %b want 01", seen); end
    n_cmp++; if (rl !== 1'b1) begin n_fail++; $display("FAIL shl_ready_low got %b want 1", rl); end
    n_cmp++; if (result !== 8'h2F) begin n_fail++; $display("FAIL shl_result got %h want 2f", result); end
  endtask

  task automatic test_back_to_back;
    int fd = 0, fl = 0, sd = 0, nacc = 0;
    logic [7:0] mid = 'x;
    bit acc;
    @(negedge clk);
    cmd_op = 2'b10; cmd_count = 4'd2; cmd_fill = 1'b0; cmd_rotate = 1'b0; cmd_data = 8'hFF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'b11; cmd_data = 8'h3C;
    for (int i = 1; i <= 20; i++) begin
      if (usr_mode == 2'b11 && fl == 0) fl = i;
      if (done && fd == 0) fd = i;
      if (done && fd != 0 && i > fd && sd == 0) sd = i;
      if (fd != 0 && i == fd + 1) mid = result;
      acc = cmd_valid && cmd_ready;
      if (acc) nacc++;
      @(posedge clk); #1;
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    n_cmp++; if (fd !== 3) begin n_fail++; $display("FAIL shr_latency got %0d want 3", fd); end
    n_cmp++; if (mid !== 8'h0B) begin n_fail++; $display("FAIL shr_result got %h want 0b", mid); end
    n_cmp++; if (fl !== 5) begin n_fail++; $display("FAIL held_load_start got %0d want 5", fl); end
    n_cmp++; if (sd !== 6) begin n_fail++; $display("FAIL held_load_done got %0d want 6", sd); end
    n_cmp++; if (nacc !== 1) begin n_fail++; $display("FAIL held_accepts got %0d want 1", nacc); end
    n_cmp++; if (result !== 8'h3C) begin n_fail++; $display("FAIL held_result got %h want 3c", result); end
  endtask

  task automatic test_nop_zero;
    int lat, nact; logic [1:0] seen; bit rl;
    run_cmd(2'b00, 4'd5, 1'b1, 1'b0, 8'hFF, lat, nact, seen, rl);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL nop_latency got %0d want 1", lat); end
    n_cmp++; if (nact !== 0) begin n_fail++; $display("FAIL nop_mode_cycles got %0d want 0", nact); end
    n_cmp++; if (result !== 8'h3C) begin n_fail++; $display("FAIL nop_result got %h want 3c", result); end
    run_cmd(2'b01, 4'd0, 1'b1, 1'b0, 8'h00, lat, nact, seen, rl);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", lat); end
    n_cmp++; if (nact !== 0) begin n_fail++; $display("FAIL zero_mode_cycles got %0d want 0", nact); end
    n_cmp++; if (result !== 8'h3C) begin n_fail++; $display("FAIL zero_result got %h want 3c", result); end
    n_cmp++; if (usr_q !== 8'h3C) begin n_fail++; $display("FAIL zero_reg got %h want 3c", usr_q); end
  endtask

  task automatic test_rotate;
    int lat, nact; logic [1:0] seen; bit rl;
    logic [7:0] exp_l, exp_r;
`ifdef USR_SEQ_ROTATE_EN
    exp_l = 8'h5A; exp_r = 8'h2D;
`else
    exp_l = 8'h50; exp_r = 8'h28;
`endif
    run_cmd(2'b11, 4'd0, 1'b0, 1'b0, 8'hA5, lat, nact, seen, rl);
    run_cmd(2'b01, 4'd4, 1'b0, 1'b1, 8'h00, lat, nact, seen, rl);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL rot_shl_latency got %0d want 5", lat); end
    n_cmp++; if (result !== exp_l) begin n_fail++; $display("FAIL rot_shl_result got %h want %h", result, exp_l); end
    run_cmd(2'b10, 4'd1, 1'b0, 1'b1, 8'h00, lat, nact, seen, rl);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rot_shr_latency got %0d want 2", lat); end
    n_cmp++; if (result !== exp_r) begin n_fail++; $display("FAIL rot_shr_result got %h want %h", result, exp_r); end
  endtask

  task automatic test_reset_mid_run;
    int lat, nact; logic [1:0] seen; bit rl;
    bit saw_done = 1'b0;
    @(negedge clk);
    cmd_op = 2'b01; cmd_count = 4'd5; cmd_fill = 1'b1; cmd_rotate = 1'b0; cmd_data = 8'h00;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (usr_mode !== 2'b01) begin n_fail++; $display("FAIL mid_mode_before got %b want 01", usr_mode); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (usr_mode !== 2'b00) begin n_fail++; $display("FAIL mid_mode_abort got %b want 00", usr_mode); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    repeat (2) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got %b want 0", saw_done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
    run_cmd(2'b11, 4'd0, 1'b0, 1'b0, 8'h77, lat, nact, seen, rl);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL post_load_latency got %0d want 2", lat); end
    n_cmp++; if (result !== 8'h77) begin n_fail++; $display("FAIL post_load_result got %h want 77", result); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_shl;
    test_back_to_back;
    test_nop_zero;
    test_rotate;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
